// File: rtl/time_ctrl_pkg.sv
// Shared types for the emulation time controller: host command opcodes and FSM states.
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_PAUSE = 2'd0,
        CMD_RUN   = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_UNTIL = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_UNTIL  = 2'd3
    } state_t;

endpackage

// File: rtl/emu_time_controller_if.sv
// Bundle of dt request inputs, host command port and time outputs of the controller.
interface emu_time_controller_if
    import time_ctrl_pkg::*;
#(
    parameter int n          = 2,
    parameter int width      = 32,
    parameter int time_width = 64
);
    logic signed [width-1:0]      dt_req [n];
    logic [n-1:0]                 dt_en;
    logic                         cmd_valid;
    logic                         cmd_ready;
    cmd_op_t                      cmd_op;
    logic [time_width-1:0]        cmd_arg;
    logic signed [width-1:0]      emu_dt;
    logic signed [time_width-1:0] emu_time;
    logic                         emu_running;
    logic                         done;

    modport master (
        output dt_req, dt_en, cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready, emu_dt, emu_time, emu_running, done
    );

    modport slave (
        input  dt_req, dt_en, cmd_valid, cmd_op, cmd_arg,
        output cmd_ready, emu_dt, emu_time, emu_running, done
    );
endinterface

// File: rtl/dt_min_reduce.sv
// Masks disabled channels to dt_max, clamps negative requests to zero and
// reduces all requests (and the ceiling) to their minimum.
module dt_min_reduce #(
    parameter int                      n      = 2,
    parameter int                      width  = 32,
    parameter logic signed [width-1:0] dt_max = {1'b0, {(width-1){1'b1}}}
) (
    input  logic signed [width-1:0] i_dt_req [n],
    input  logic [n-1:0]            i_dt_en,
    output logic signed [width-1:0] o_m
);
    logic signed [width-1:0] w_chain [n+1];

    // Seeding with the ceiling makes the all-disabled case fall out as dt_max.
    assign w_chain[0] = dt_max;

    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_chain
            logic signed [width-1:0] w_r;
            assign w_r = !i_dt_en[gi]          ? dt_max :
                         i_dt_req[gi][width-1] ? '0     : i_dt_req[gi];
            assign w_chain[gi+1] = (w_r < w_chain[gi]) ? w_r : w_chain[gi];
        end
    endgenerate

    assign o_m = w_chain[n];
endmodule

// File: rtl/emu_time_controller.sv
// Global emulation time manager: picks emu_dt from the channel minimum and the
// host run mode, accumulates emu_time and handles PAUSE/RUN/STEP/UNTIL commands.
module emu_time_controller
    import time_ctrl_pkg::*;
#(
    parameter int                      n             = 2,
    parameter int                      width         = 32,
    parameter int                      time_width    = 64,
    parameter logic signed [width-1:0] dt_max        = {1'b0, {(width-1){1'b1}}},
    parameter bit                      start_running = 1'b1
) (
    input logic                  emu_clk,
    input logic                  emu_rst,
    emu_time_controller_if.slave bus
);
    localparam state_t reset_state = state_t'(start_running ? ST_RUN : ST_PAUSED);

    state_t                       r_state;
    logic signed [time_width-1:0] r_time;
    logic [time_width-1:0]        r_cnt;
    logic signed [time_width-1:0] r_target;
    logic                         r_done;
    logic                         r_running;

    state_t                       w_state_next;
    logic [time_width-1:0]        w_cnt_next;
    logic signed [time_width-1:0] w_target_next;
    logic                         w_done_next;
    logic                         w_ready;
    logic signed [width-1:0]      w_m;
    logic signed [width-1:0]      w_dt;
    logic signed [time_width-1:0] w_m_ext;
    logic signed [time_width-1:0] w_dt_ext;
    logic signed [time_width-1:0] w_rem;
    logic signed [time_width-1:0] w_time_next;

    dt_min_reduce #(
        .n      (n),
        .width  (width),
        .dt_max (dt_max)
    ) u_dt_min (
        .i_dt_req (bus.dt_req),
        .i_dt_en  (bus.dt_en),
        .o_m      (w_m)
    );

    assign w_m_ext = time_width'(w_m);
    assign w_rem   = r_target - r_time;

    // In UNTIL the remaining distance is bounded by m, so the narrowed value fits.
    always_comb begin
        w_dt = w_m;
        case (r_state)
            ST_PAUSED: w_dt = '0;
            ST_UNTIL:  w_dt = (w_rem < w_m_ext) ? w_rem[width-1:0] : w_m;
            default:   w_dt = w_m;
        endcase
    end

    assign w_dt_ext    = time_width'(w_dt);
    assign w_time_next = r_time + w_dt_ext;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_target_next = r_target;
        w_done_next   = 1'b0;
        w_ready       = (r_state == ST_PAUSED) || (r_state == ST_RUN) ||
                        (bus.cmd_op == CMD_PAUSE);

        case (r_state)
            ST_STEP: begin
                w_cnt_next = r_cnt - time_width'(1);
                if (r_cnt == time_width'(1)) begin
                    w_state_next = ST_PAUSED;
                    w_done_next  = 1'b1;
                end
            end
            ST_UNTIL: begin
                if (w_time_next == r_target) begin
                    w_state_next = ST_PAUSED;
                    w_done_next  = 1'b1;
                end
            end
            default: ;
        endcase

        // An accepted command wins over a same-cycle completion; done survives.
        if (bus.cmd_valid && w_ready) begin
            case (bus.cmd_op)
                CMD_PAUSE: w_state_next = ST_PAUSED;
                CMD_RUN:   w_state_next = ST_RUN;
                CMD_STEP: begin
                    if (bus.cmd_arg == '0) begin
                        w_state_next = ST_PAUSED;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = ST_STEP;
                        w_cnt_next   = bus.cmd_arg;
                    end
                end
                default: begin
                    if ($signed(bus.cmd_arg) <= r_time) begin
                        w_state_next = ST_PAUSED;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next  = ST_UNTIL;
                        w_target_next = $signed(bus.cmd_arg);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_state   <= reset_state;
            r_time    <= '0;
            r_cnt     <= '0;
            r_target  <= '0;
            r_done    <= 1'b0;
            r_running <= start_running;
        end else begin
            r_state   <= w_state_next;
            r_time    <= w_time_next;
            r_cnt     <= w_cnt_next;
            r_target  <= w_target_next;
            r_done    <= w_done_next;
            r_running <= (w_state_next != ST_PAUSED);
        end
    end

    assign bus.cmd_ready   = w_ready;
    assign bus.emu_dt      = w_dt;
    assign bus.emu_time    = r_time;
    assign bus.emu_running = r_running;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_emu_time_controller.sv
// Directed bench: a start-running build (a) and a start-paused build (b), both n=3, dt_max=100.
module tb_emu_time_controller;
    import time_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    emu_time_controller_if #(.n(3), .width(32), .time_width(64)) ifa ();
    emu_time_controller_if #(.n(3), .width(32), .time_width(64)) ifb ();

    emu_time_controller #(
        .n(3), .width(32), .time_width(64), .dt_max(32'sd100), .start_running(1'b1)
    ) dut_a (
        .emu_clk (clk),
        .emu_rst (rst_a),
        .bus     (ifa)
    );

    emu_time_controller #(
        .n(3), .width(32), .time_width(64), .dt_max(32'sd100), .start_running(1'b0)
    ) dut_b (
        .emu_clk (clk),
        .emu_rst (rst_b),
        .bus     (ifb)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input int r0, input int r1, input int r2, input logic [2:0] en);
        ifa.dt_req[0] = r0; ifa.dt_req[1] = r1; ifa.dt_req[2] = r2; ifa.dt_en = en;
    endtask

    task automatic req_b(input int r0, input int r1, input int r2, input logic [2:0] en);
        ifb.dt_req[0] = r0; ifb.dt_req[1] = r1; ifb.dt_req[2] = r2; ifb.dt_en = en;
    endtask

    task automatic cmd_a(input cmd_op_t op, input longint arg);
        ifa.cmd_valid = 1'b1; ifa.cmd_op = op; ifa.cmd_arg = arg;
    endtask

    task automatic cmd_b(input cmd_op_t op, input longint arg);
        ifb.cmd_valid = 1'b1; ifb.cmd_op = op; ifb.cmd_arg = arg;
    endtask

    task automatic idle_a();
        ifa.cmd_valid = 1'b0; ifa.cmd_op = CMD_PAUSE; ifa.cmd_arg = '0;
    endtask

    task automatic idle_b();
        ifb.cmd_valid = 1'b0; ifb.cmd_op = CMD_PAUSE; ifb.cmd_arg = '0;
    endtask

    int exp_dt   [4] = '{6, 6, 6, 2};
    int exp_time [4] = '{6, 12, 18, 20};

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a(5, 3, 7, 3'b111);
        req_b(6, 8, 9, 3'b111);
        idle_a();
        idle_b();
        #2;
        check("rst_a_time", ifa.emu_time, 0);
        check("rst_a_done", ifa.done, 0);
        check("rst_a_running", ifa.emu_running, 1);
        check("rst_b_running", ifb.emu_running, 0);
        check("rst_b_dt", ifb.emu_dt, 0);
        tick();
        tick();
        check("rst_a_hold_time", ifa.emu_time, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // run: min of {5,3,7} each cycle
        #1;
        check("run_dt", ifa.emu_dt, 3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("run_time", ifa.emu_time, 3 * k);
        end

        // enable masking, dt_max ceiling, negative clamp
        req_a(5, 3, 7, 3'b101);
        #1 check("mask_dt", ifa.emu_dt, 5);
        ifa.dt_en = 3'b000;
        #1 check("none_en_dt", ifa.emu_dt, 100);
        req_a(200, 150, 120, 3'b111);
        #1 check("ceiling_dt", ifa.emu_dt, 100);
        req_a(-4, 3, 7, 3'b001);
        #1 check("neg_clamp_dt", ifa.emu_dt, 0);
        tick();
        check("neg_clamp_time", ifa.emu_time, 9);

        // pause at 9
        cmd_a(CMD_PAUSE, 0);
        #1 check("pause_ready", ifa.cmd_ready, 1);
        tick();
        idle_a();
        check("pause_running", ifa.emu_running, 0);
        check("pause_time", ifa.emu_time, 9);
        req_a(5, 3, 7, 3'b111);
        #1 check("pause_dt", ifa.emu_dt, 0);
        tick();
        check("pause_frozen", ifa.emu_time, 9);

        // step 4 cycles of dt=3
        cmd_a(CMD_STEP, 4);
        tick();
        idle_a();
        check("step_running", ifa.emu_running, 1);
        check("step_start_time", ifa.emu_time, 9);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("step_time", ifa.emu_time, 9 + 3 * k);
            check("step_done", ifa.done, (k == 4) ? 1 : 0);
        end
        check("step_end_running", ifa.emu_running, 0);
        tick();
        check("step_done_clear", ifa.done, 0);
        check("step_end_time", ifa.emu_time, 21);
        check("step_end_dt", ifa.emu_dt, 0);

        // RUN refused during STEP; step still completes
        cmd_a(CMD_STEP, 3);
        tick();
        cmd_a(CMD_RUN, 0);
        #1 check("step_run_ready", ifa.cmd_ready, 0);
        tick();
        tick();
        tick();
        idle_a();
        check("step_run_done", ifa.done, 1);
        check("step_run_time", ifa.emu_time, 30);
        check("step_run_running", ifa.emu_running, 0);

        // PAUSE mid-step: no done
        cmd_a(CMD_STEP, 3);
        tick();
        idle_a();
        tick();
        cmd_a(CMD_PAUSE, 0);
        #1 check("step_pause_ready", ifa.cmd_ready, 1);
        tick();
        idle_a();
        check("step_pause_running", ifa.emu_running, 0);
        check("step_pause_done", ifa.done, 0);
        check("step_pause_time", ifa.emu_time, 36);
        tick();
        check("step_pause_frozen", ifa.emu_time, 36);

        // PAUSE coinciding with expiry still pulses done
        cmd_a(CMD_STEP, 1);
        tick();
        cmd_a(CMD_PAUSE, 0);
        tick();
        idle_a();
        check("expire_pause_done", ifa.done, 1);
        check("expire_pause_time", ifa.emu_time, 39);
        check("expire_pause_running", ifa.emu_running, 0);
        tick();
        check("expire_pause_clear", ifa.done, 0);

        // STEP 0 completes immediately
        cmd_a(CMD_STEP, 0);
        tick();
        idle_a();
        check("step0_done", ifa.done, 1);
        check("step0_running", ifa.emu_running, 0);
        check("step0_time", ifa.emu_time, 39);

        // until 20 from time 0 with m=6
        check("until_start_time", ifb.emu_time, 0);
        cmd_b(CMD_UNTIL, 20);
        tick();
        idle_b();
        check("until_running", ifb.emu_running, 1);
        for (int k = 0; k < 4; k++) begin
            check("until_dt", ifb.emu_dt, exp_dt[k]);
            tick();
            check("until_time", ifb.emu_time, exp_time[k]);
            check("until_done", ifb.done, (k == 3) ? 1 : 0);
        end
        check("until_end_dt", ifb.emu_dt, 0);
        check("until_end_running", ifb.emu_running, 0);
        tick();
        check("until_done_clear", ifb.done, 0);
        check("until_end_time", ifb.emu_time, 20);

        // target already behind us
        cmd_b(CMD_UNTIL, 15);
        tick();
        idle_b();
        check("until_past_done", ifb.done, 1);
        check("until_past_time", ifb.emu_time, 20);
        check("until_past_running", ifb.emu_running, 0);

        // asynchronous reset mid-UNTIL
        cmd_b(CMD_UNTIL, 1000);
        tick();
        idle_b();
        tick();
        tick();
        check("pre_rst_time", ifb.emu_time, 32);
        #3 rst_b = 1'b1;
        #1;
        check("arst_time", ifb.emu_time, 0);
        check("arst_running", ifb.emu_running, 0);
        check("arst_dt", ifb.emu_dt, 0);
        check("arst_done", ifb.done, 0);
        tick();
        check("arst_hold_done", ifb.done, 0);
        rst_b = 1'b0;
        tick();
        check("post_rst_time", ifb.emu_time, 0);
        check("post_rst_dt", ifb.emu_dt, 0);
        check("post_rst_running", ifb.emu_running, 0);
        check("post_rst_done", ifb.done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/emu_time_controller.md
Name: emu_time_controller

Overview:
- Next-generation emulation time manager.
- Reduces N per-channel timestep requests to one global emu_dt and accumulates emu_time.
- Adds per-channel enables, a global dt ceiling, and dt clamping, plus host-controlled run/pause/step/run-until modes via a valid/ready command port.
- Sits at the top of the emulator; feeds emu_dt/emu_time to all analog models and answers the debug/host controller.

Parameters:
- n, 2, number of dt request channels (>=1)
- width, 32, signed width of dt_req and emu_dt
- time_width, 64, signed width of emu_time and cmd_arg (>= width)
- dt_max, 2**(width-1)-1, global dt ceiling (positive)
- start_running, 1, 1 = leave reset in RUN; 0 = leave reset in PAUSED

Ports:
- emu_clk  in  1  emulator clock
- emu_rst  in  1  reset; asynchronous, active-high
- dt_req  in  width x n (signed, unpacked array)  per-channel requested timestep
- dt_en  in  n  per-channel enable; a disabled channel does not constrain dt
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0 PAUSE, 1 RUN, 2 STEP, 3 UNTIL
- cmd_arg  in  time_width  STEP: cycle count (unsigned); UNTIL: target time (signed)
- emu_dt  out  width (signed)  timestep applied this cycle
- emu_time  out  time_width (signed)  accumulated emulation time
- emu_running  out  1  high in RUN, STEP and UNTIL
- done  out  1  one-cycle pulse when STEP or UNTIL completes

Behaviour:
- One clock (emu_clk). emu_rst is asynchronous, active-high; all state clears immediately on assertion.
- Reset values:
  - emu_time = 0, done = 0, step counter = 0, target = 0.
  - state = RUN if start_running=1, else PAUSED.
- States: PAUSED, RUN, STEP, UNTIL.
- dt computation (combinational, same cycle):
  - Each request r_k = dt_req[k] if dt_en[k] is high, else dt_max.
  - Negative requests are clamped to 0.
  - m = min(dt_max, all r_k). If no channel is enabled, m = dt_max.
  - PAUSED: emu_dt = 0.
  - RUN and STEP: emu_dt = m.
  - UNTIL: emu_dt = min(m, target - emu_time). The difference is computed at time_width and fits width after the min.
- Time accumulation:
  - emu_time <= emu_time + sign-extended emu_dt on every posedge.
  - Wraps modulo 2**time_width with no saturation.
- cmd_ready:
  - 1 in PAUSED and RUN.
  - In STEP or UNTIL, 1 only when cmd_op == PAUSE.
- Accepted command takes effect at the next edge. It overrides any completion in the same cycle; done is still pulsed if the completion fired.
  - PAUSE -> PAUSED.
  - RUN -> RUN.
  - STEP, arg == 0 -> PAUSED with done pulsed next cycle. Otherwise STEP, counter = arg.
  - UNTIL, arg <= emu_time -> PAUSED with done pulsed. Otherwise UNTIL, target = arg.
- STEP:
  - The counter decrements each cycle.
  - When the counter == 1, the next state is PAUSED and done is pulsed. Exactly arg cycles apply a nonzero-capable dt.
- UNTIL:
  - When emu_time + emu_dt == target, the next state is PAUSED and done is pulsed.
  - If m == 0 the block stays in UNTIL (stall); there is no timeout.
- done is registered, asserted exactly one cycle, and never asserted in RUN.
- Reset mid-STEP/UNTIL: the operation is abandoned, done is not pulsed, and the block goes to the reset state.
- emu_running = (state != PAUSED), registered from state.

Decomposition:
- Package time_ctrl_pkg:
  - cmd_op_t enum (CMD_PAUSE, CMD_RUN, CMD_STEP, CMD_UNTIL).
  - state_t enum (ST_PAUSED, ST_RUN, ST_STEP, ST_UNTIL).
- Sub-module dt_min_reduce (parameters n, width, dt_max): enable masking, negative clamp, and min reduction, producing m.
  - Linear chain for now; may become a tree later.
- The top level holds the FSM, counter, target register and time accumulator.

Test Plan:
1. Reset with start_running=1, n=3, dt_req={5,3,7}, dt_en=3'b111 -> emu_dt=3 each cycle; emu_time 0,3,6,9.
2. Same setup, dt_en=3'b101, then dt_en=0 with dt_max=100 -> emu_dt=5, then 100. Drive dt_req[0]=-4 with enabled -> emu_dt=0 and time holds.
3. PAUSE accepted at emu_time=9 -> emu_dt=0, emu_running=0, time frozen at 9. Then STEP arg=4 with dt=3 -> time 12,15,18,21; done pulses one cycle; state PAUSED.
4. UNTIL arg=20 from time 0 with m=6 -> emu_dt 6,6,6,2; time reaches exactly 20; done pulses; emu_dt=0 after. Then UNTIL arg=15 -> immediate done with time unchanged.
5. In STEP, a RUN command -> cmd_ready=0, no state change. A PAUSE command -> accepted, PAUSED next cycle, no done unless the count expired that same cycle.
6. Assert emu_rst asynchronously mid-UNTIL -> outputs take reset values immediately; no done pulse; start_running=0 build comes out PAUSED with emu_dt=0.
